// File: rtl/mycpu_defs_pkg.sv
// Shared definitions for the MIPS core pipeline: load opcodes, reset PC and
// the memory-to-writeback bundle layout.
package mycpu_defs;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;
    localparam logic [2:0] LD_LWL  = 3'd6;
    localparam logic [2:0] LD_LWR  = 3'd7;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [2:0]  ld_op;
        logic [31:0] ld_data;
        logic [31:0] rt_old;
    } ms_to_ws_bus_t;

    localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_bus_t);

endpackage

// File: rtl/load_align.sv
// Combinational load-data alignment: byte/halfword extraction with sign or
// zero extension, plus LWL/LWR merging with the old rt value.
module load_align
    import mycpu_defs::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  off,
    input  logic [31:0] d,
    input  logic [31:0] rt,
    input  logic [31:0] alu_result,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword from the raw word.
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'd0:    byte_s = d[7:0];
            2'd1:    byte_s = d[15:8];
            2'd2:    byte_s = d[23:16];
            2'd3:    byte_s = d[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off[1]) begin
            half_s = d[31:16];
        end else begin
            half_s = d[15:0];
        end
    end

    // Build the final write-back value for each load kind.
    always_comb begin
        result = alu_result;
        case (ld_op)
            LD_NONE: result = alu_result;
            LD_LB:   result = {{24{byte_s[7]}}, byte_s};
            LD_LBU:  result = {24'h00_0000, byte_s};
            LD_LH:   result = {{16{half_s[15]}}, half_s};
            LD_LHU:  result = {16'h0000, half_s};
            LD_LW:   result = d;
            LD_LWL: begin
                case (off)
                    2'd0:    result = {d[7:0],  rt[23:0]};
                    2'd1:    result = {d[15:0], rt[15:0]};
                    2'd2:    result = {d[23:0], rt[7:0]};
                    2'd3:    result = d;
                    default: result = d;
                endcase
            end
            LD_LWR: begin
                case (off)
                    2'd0:    result = d;
                    2'd1:    result = {rt[31:24], d[31:8]};
                    2'd2:    result = {rt[31:16], d[31:16]};
                    2'd3:    result = {rt[31:8],  d[31:24]};
                    default: result = d;
                endcase
            end
            default: result = alu_result;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Write-back stage: holds the memory-stage result under a valid/allowin
// handshake, aligns load data and drives the register-file write port.
module mem_wb_stage
    import mycpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic        ms_gr_we,
    input  logic [4:0]  ms_dest,
    input  logic [31:0] ms_alu_result,
    input  logic [2:0]  ms_ld_op,
    input  logic [31:0] ms_ld_data,
    input  logic [31:0] ms_rt_old,
    input  logic        ws_flush,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        ws_fwd_valid,
    output logic [4:0]  ws_fwd_dest,
    output logic [31:0] ws_fwd_data,
    output logic [31:0] debug_wb_pc
);

    logic          ws_valid_r;
    ms_to_ws_bus_t ws_bus_r;
    ms_to_ws_bus_t ms_bus_s;
    logic          ws_ready_go_s;
    logic          accept_s;
    logic [31:0]   wb_result_s;

    assign ws_ready_go_s = 1'b1;
    assign ws_allowin    = !ws_valid_r || ws_ready_go_s;
    // A flush on the same edge wins, so the incoming instruction is not taken.
    assign accept_s      = ms_to_ws_valid && ws_allowin && !ws_flush;

    assign ms_bus_s = '{
        pc:         ms_pc,
        gr_we:      ms_gr_we,
        dest:       ms_dest,
        alu_result: ms_alu_result,
        ld_op:      ms_ld_op,
        ld_data:    ms_ld_data,
        rt_old:     ms_rt_old
    };

    // Stage valid bit and latched instruction bundle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid_r          <= 1'b0;
            ws_bus_r.pc         <= RESET_PC;
            ws_bus_r.gr_we      <= 1'b0;
            ws_bus_r.dest       <= 5'd0;
            ws_bus_r.alu_result <= 32'h0000_0000;
            ws_bus_r.ld_op      <= LD_NONE;
            ws_bus_r.ld_data    <= 32'h0000_0000;
            ws_bus_r.rt_old     <= 32'h0000_0000;
        end else begin
            if (ws_flush) begin
                ws_valid_r <= 1'b0;
            end else if (ws_allowin) begin
                ws_valid_r <= ms_to_ws_valid;
            end
            if (accept_s) begin
                ws_bus_r <= ms_bus_s;
            end
        end
    end

    load_align u_load_align (
        .ld_op      (ws_bus_r.ld_op),
        .off        (ws_bus_r.alu_result[1:0]),
        .d          (ws_bus_r.ld_data),
        .rt         (ws_bus_r.rt_old),
        .alu_result (ws_bus_r.alu_result),
        .result     (wb_result_s)
    );

    // dest 0 still raises rf_wen; the register file itself ignores r0.
    assign rf_wen       = ws_valid_r && ws_bus_r.gr_we && !ws_flush;
    assign rf_waddr     = ws_bus_r.dest;
    assign rf_wdata     = wb_result_s;
    assign ws_fwd_valid = ws_valid_r && ws_bus_r.gr_we;
    assign ws_fwd_dest  = ws_bus_r.dest;
    assign ws_fwd_data  = wb_result_s;
    assign debug_wb_pc  = ws_bus_r.pc;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

    logic        clk;
    logic        resetn;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_alu_result;
    logic [2:0]  ms_ld_op;
    logic [31:0] ms_ld_data;
    logic [31:0] ms_rt_old;
    logic        ws_flush;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_fwd_valid;
    logic [4:0]  ws_fwd_dest;
    logic [31:0] ws_fwd_data;
    logic [31:0] debug_wb_pc;

    int n_compared;
    int n_mismatched;

    mem_wb_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ws_allowin     (ws_allowin),
        .ms_pc          (ms_pc),
        .ms_gr_we       (ms_gr_we),
        .ms_dest        (ms_dest),
        .ms_alu_result  (ms_alu_result),
        .ms_ld_op       (ms_ld_op),
        .ms_ld_data     (ms_ld_data),
        .ms_rt_old      (ms_rt_old),
        .ws_flush       (ws_flush),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .ws_fwd_valid   (ws_fwd_valid),
        .ws_fwd_dest    (ws_fwd_dest),
        .ws_fwd_data    (ws_fwd_data),
        .debug_wb_pc    (debug_wb_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction at the negedge; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                         input logic [31:0] alu, input logic [2:0] op,
                         input logic [31:0] d, input logic [31:0] rt);
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_pc          = pc;
        ms_gr_we       = we;
        ms_dest        = dest;
        ms_alu_result  = alu;
        ms_ld_op       = op;
        ms_ld_data     = d;
        ms_rt_old      = rt;
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic check_wb(input string tag, input logic [4:0] dest, input logic [31:0] data);
        check_value({tag, ".wen"},   {31'd0, rf_wen},   32'd1);
        check_value({tag, ".waddr"}, {27'd0, rf_waddr}, {27'd0, dest});
        check_value({tag, ".wdata"}, rf_wdata, data);
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  op;
        logic [31:0] alu;
        logic [31:0] d;
        logic [31:0] rt;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t vecs[$];

    initial begin
        n_compared     = 0;
        n_mismatched   = 0;
        resetn         = 1'b0;
        ms_to_ws_valid = 1'b0;
        ms_pc          = 32'h0;
        ms_gr_we       = 1'b0;
        ms_dest        = 5'd0;
        ms_alu_result  = 32'h0;
        ms_ld_op       = 3'd0;
        ms_ld_data     = 32'h0;
        ms_rt_old      = 32'h0;
        ws_flush       = 1'b0;

        #12;
        check_value("rst.wen_during", {31'd0, rf_wen}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check_value("idle.wen",     {31'd0, rf_wen},       32'd0);
        check_value("idle.allowin", {31'd0, ws_allowin},   32'd1);
        check_value("idle.dbgpc",   debug_wb_pc,           32'hBFC0_0000);
        check_value("idle.fwdv",    {31'd0, ws_fwd_valid}, 32'd0);

        // LW with full forwarding/debug checks
        issue(32'h0000_0100, 1'b1, 5'd5, 32'h0000_1000, 3'd5, 32'h1234_5678, 32'h0);
        check_wb("lw", 5'd5, 32'h1234_5678);
        check_value("lw.dbgpc",   debug_wb_pc, 32'h0000_0100);
        check_value("lw.fwdv",    {31'd0, ws_fwd_valid}, 32'd1);
        check_value("lw.fwddest", {27'd0, ws_fwd_dest},  32'd5);
        check_value("lw.fwddata", ws_fwd_data, 32'h1234_5678);
        @(posedge clk);
        #1;
        check_value("lw.after_wen",  {31'd0, rf_wen}, 32'd0);
        check_value("lw.hold_dbgpc", debug_wb_pc, 32'h0000_0100);
        check_value("lw.hold_waddr", {27'd0, rf_waddr}, 32'd5);

        vecs.push_back('{"lb_off3",   3'd1, 32'h0000_2003, 32'h8012_3456, 32'h0,          32'hFFFF_FF80});
        vecs.push_back('{"lbu_off3",  3'd2, 32'h0000_2003, 32'h8012_3456, 32'h0,          32'h0000_0080});
        vecs.push_back('{"lb_off1",   3'd1, 32'h0000_2001, 32'h1234_7F56, 32'h0,          32'h0000_007F});
        vecs.push_back('{"lhu_off2",  3'd4, 32'h0000_2002, 32'h8001_1234, 32'h0,          32'h0000_8001});
        vecs.push_back('{"lh_off2",   3'd3, 32'h0000_2002, 32'h8001_1234, 32'h0,          32'hFFFF_8001});
        vecs.push_back('{"lh_off0",   3'd3, 32'h0000_2000, 32'h1234_8765, 32'h0,          32'hFFFF_8765});
        vecs.push_back('{"lwl_off1",  3'd6, 32'h0000_2001, 32'hAABB_CCDD, 32'h1122_3344, 32'hCCDD_3344});
        vecs.push_back('{"lwr_off2",  3'd7, 32'h0000_2002, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_AABB});
        vecs.push_back('{"lwl_off0",  3'd6, 32'h0000_2000, 32'hAABB_CCDD, 32'h1122_3344, 32'hDD22_3344});
        vecs.push_back('{"lwl_off3",  3'd6, 32'h0000_2003, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD});
        vecs.push_back('{"lwr_off0",  3'd7, 32'h0000_2000, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD});
        vecs.push_back('{"lwr_off3",  3'd7, 32'h0000_2003, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_33AA});
        vecs.push_back('{"alu_op",    3'd0, 32'hDEAD_BEEF, 32'h5555_5555, 32'h0,          32'hDEAD_BEEF});

        foreach (vecs[i]) begin
            issue(32'h0000_0200 + 32'(i) * 32'd4, 1'b1, 5'd9, vecs[i].alu, vecs[i].op,
                  vecs[i].d, vecs[i].rt);
            check_value({vecs[i].tag, ".wdata"}, rf_wdata, vecs[i].exp);
        end

        // Back-to-back ALU instructions, dest 3 then dest 4
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_pc = 32'h0000_0300; ms_gr_we = 1'b1; ms_dest = 5'd3;
        ms_alu_result = 32'h0000_0033; ms_ld_op = 3'd0;
        @(posedge clk);
        #1;
        check_wb("b2b0", 5'd3, 32'h0000_0033);
        check_value("b2b0.fwddest", {27'd0, ws_fwd_dest}, 32'd3);
        ms_pc = 32'h0000_0304; ms_dest = 5'd4; ms_alu_result = 32'h0000_0044;
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
        check_wb("b2b1", 5'd4, 32'h0000_0044);
        check_value("b2b1.fwddest", {27'd0, ws_fwd_dest}, 32'd4);
        check_value("b2b1.fwddata", ws_fwd_data, 32'h0000_0044);
        check_value("b2b1.dbgpc",   debug_wb_pc, 32'h0000_0304);

        // Non-writing instruction
        issue(32'h0000_0400, 1'b0, 5'd6, 32'h0000_0066, 3'd0, 32'h0, 32'h0);
        check_value("nowe.wen",  {31'd0, rf_wen},       32'd0);
        check_value("nowe.fwdv", {31'd0, ws_fwd_valid}, 32'd0);

        // Flush together with an incoming instruction
        issue(32'h0000_0500, 1'b1, 5'd7, 32'h0000_0077, 3'd0, 32'h0, 32'h0);
        check_wb("preflush", 5'd7, 32'h0000_0077);
        ms_to_ws_valid = 1'b1;
        ms_dest        = 5'd8;
        ws_flush       = 1'b1;
        #1;
        check_value("flush.wen_now", {31'd0, rf_wen}, 32'd0);
        @(posedge clk);
        #1;
        ws_flush       = 1'b0;
        ms_to_ws_valid = 1'b0;
        check_value("flush.wen_next", {31'd0, rf_wen},       32'd0);
        check_value("flush.fwdv",     {31'd0, ws_fwd_valid}, 32'd0);

        // Asynchronous reset mid-instruction
        issue(32'h0000_0600, 1'b1, 5'd10, 32'h0000_00AA, 3'd0, 32'h0, 32'h0);
        check_wb("prerst", 5'd10, 32'h0000_00AA);
        #2;
        resetn = 1'b0;
        #1;
        check_value("arst.wen",   {31'd0, rf_wen}, 32'd0);
        check_value("arst.dbgpc", debug_wb_pc,     32'hBFC0_0000);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check_value("arst.allowin", {31'd0, ws_allowin}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
